// File: rtl/fpadd_result_stage.sv
// Result stage for the floating-point adder: a 2-entry FIFO that right-justifies
// results by precision, accumulates sticky exception flags and counts accepted results.
module fpadd_result_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_result,
   input  logic [4:0]  in_flags,
   input  logic        in_denorm,
   input  logic [1:0]  in_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic [4:0]  out_flags,
   output logic        out_denorm,
   input  logic        flag_clr,
   output logic [4:0]  sticky_flags,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t      state;
   logic [63:0] tail_data;
   logic [4:0]  tail_flags;
   logic        tail_denorm;
   logic [63:0] ext_data;
   logic        push;
   logic        pop;

   // Results arrive MSB-justified; reserved precision falls back to double.
   always_comb begin
      ext_data = in_result;
      case (in_p)
         2'b10:   ext_data = {48'h0, in_result[63:48]};
         2'b01:   ext_data = {32'h0, in_result[63:32]};
         default: ext_data = in_result;
      endcase
   end

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // The out_* registers are the head slot; the tail slot is only used in FULL.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= EMPTY;
         out_data    <= 64'h0;
         out_flags   <= 5'h0;
         out_denorm  <= 1'b0;
         tail_data   <= 64'h0;
         tail_flags  <= 5'h0;
         tail_denorm <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  out_data   <= ext_data;
                  out_flags  <= in_flags;
                  out_denorm <= in_denorm;
                  state      <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  out_data   <= ext_data;
                  out_flags  <= in_flags;
                  out_denorm <= in_denorm;
               end else if (push) begin
                  tail_data   <= ext_data;
                  tail_flags  <= in_flags;
                  tail_denorm <= in_denorm;
                  state       <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  out_data   <= tail_data;
                  out_flags  <= tail_flags;
                  out_denorm <= tail_denorm;
                  state      <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // A clear in the same cycle as a push keeps only the new flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_flags <= 5'h0;
         op_count     <= 16'h0;
      end else begin
         if (flag_clr)
            sticky_flags <= push ? in_flags : 5'h0;
         else if (push)
            sticky_flags <= sticky_flags | in_flags;
         if (push)
            op_count <= op_count + 16'd1;
      end
   end

endmodule

// File: doc/fpadd_result_stage.md
FPADD_RESULT_STAGE -- requirements
Module: fpadd_result_stage

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  fpadd result presented this cycle.
REQ-005 in_ready  output  1  stage can accept a result.
REQ-006 in_result  input  64  fpadd result, MSB-justified (half in [63:48], single in [63:32], double in [63:0]).
REQ-007 in_flags  input  5  fpadd exception flags {NV,DZ,OF,UF,NX}, bit 4 down to bit 0.
REQ-008 in_denorm  input  1  fpadd denormal-result indicator.
REQ-009 in_p  input  2  precision: 2'b00 double, 2'b01 single, 2'b10 half, 2'b11 reserved.
REQ-010 out_valid  output  1  out_* holds a valid entry.
REQ-011 out_ready  input  1  consumer accepts the entry.
REQ-012 out_data  output  64  result, right-justified and zero-extended.
REQ-013 out_flags  output  5  flags of the head entry.
REQ-014 out_denorm  output  1  denorm bit of the head entry.
REQ-015 flag_clr  input  1  clear the sticky flags.
REQ-016 sticky_flags  output  5  OR of the flags of all accepted entries since the last clear.
REQ-017 op_count  output  16  count of accepted entries.

Function
REQ-018 Push SHALL occur when in_valid and in_ready are both 1; pop SHALL occur when out_valid and out_ready are both 1.
REQ-019 Storage SHALL be a 2-entry FIFO with states EMPTY, ONE and FULL; the state SHALL change only on clk edges.
REQ-020 State transitions:
- EMPTY: push -> ONE.
- ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop -> ONE.
- FULL: pop -> ONE. A push cannot occur in FULL.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; in_ready SHALL be derived from state only and SHALL not depend combinationally on out_ready.
REQ-022 out_valid SHALL be 1 in ONE and FULL; out_data, out_flags and out_denorm SHALL come from the head entry, with no combinational path from in_*.
REQ-023 Latency SHALL be 1 cycle: data pushed at edge N SHALL appear on out_* after edge N if the FIFO was EMPTY.
REQ-024 Ordering SHALL be strict FIFO; the head entry SHALL hold stable while out_valid is 1 and out_ready is 0.
REQ-025 Extraction SHALL occur at push time, using in_p:
- half: {48'h0, in_result[63:48]}.
- single: {32'h0, in_result[63:32]}.
- double: in_result.
- reserved (2'b11): treated as double.
REQ-026 On every push, sticky_flags SHALL become sticky_flags OR in_flags.
REQ-027 When flag_clr is 1 with no push, sticky_flags SHALL become 0.
REQ-028 When flag_clr is 1 and a push occurs in the same cycle, sticky_flags SHALL become in_flags (clear applies first).
REQ-029 op_count SHALL increment by 1 on each push and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 in_valid=1 with in_ready=0 SHALL have no effect on the FIFO, sticky_flags or op_count.

Reset
REQ-031 While reset is 1 at a clk edge, the block SHALL take these values:
- state = EMPTY, so out_valid=0 and in_ready=1.
- out_data=0, out_flags=0, out_denorm=0.
- sticky_flags=0, op_count=0.
REQ-032 Reset SHALL override push, pop and flag_clr in the same cycle; entries held when reset asserts mid-operation SHALL be discarded.

Verification
REQ-033 Extraction: push in_result=64'h3C00_0000_0000_0000 with in_p=2'b10 and out_ready=1 -> next cycle out_valid=1 and out_data=64'h0000_0000_0000_3C00; push 64'h3F80_0000_xxxx_xxxx with in_p=2'b01 -> out_data=64'h0000_0000_3F80_0000.
REQ-034 Backpressure: out_ready=0 with three back-to-back pushes A, B, C -> A and B accepted, in_ready=0 after the second push, C held off; then out_ready=1 -> outputs A, B, C in order, op_count=3.
REQ-035 Sticky flags: push flags 5'b00001 then 5'b00100 -> sticky_flags=5'b00101; assert flag_clr together with a push of flags 5'b10000 -> sticky_flags=5'b10000.
REQ-036 Simultaneous push and pop in ONE -> stays ONE, out_valid stays 1, and the new entry becomes the head after the pop.
REQ-037 Counter wrap: 65536 pushes -> op_count=16'h0000; the next push -> 16'h0001.
REQ-038 Reset mid-operation: FIFO FULL with sticky_flags nonzero, then reset=1 for one cycle -> out_valid=0, in_ready=1, sticky_flags=0, op_count=0, and stale entries never appear on out_*.
